// File: rtl/fft_seq_if.sv
// Control and addressing bundle between the FFT stage sequencer and its environment.
// The master side is the sequencer; the slave side issues start/hold and returns bfly_oact.
interface fft_seq_if #(
    parameter int unsigned FFT_N = 10
);
    localparam int unsigned SW = $clog2(FFT_N);

    logic             start;
    logic             hold;
    logic             bfly_oact;
    logic             busy;
    logic             done;
    logic [SW-1:0]    stage;
    logic             bfly_act;
    logic [1:0]       bfly_ctrl;
    logic [FFT_N-2:0] bfly_idx;
    logic [FFT_N-1:0] rd_addr_a;
    logic [FFT_N-1:0] rd_addr_b;
    logic [FFT_N-2:0] tw_addr;

    modport master (
        input  start, hold, bfly_oact,
        output busy, done, stage, bfly_act, bfly_ctrl, bfly_idx, rd_addr_a, rd_addr_b, tw_addr
    );

    modport slave (
        output start, hold, bfly_oact,
        input  busy, done, stage, bfly_act, bfly_ctrl, bfly_idx, rd_addr_a, rd_addr_b, tw_addr
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIF stage sequencer: issues N/2 butterflies per stage with operand and
// twiddle addresses, then drains until every issued butterfly has retired before the next stage.
module fft_stage_sequencer #(
    parameter int unsigned FFT_N        = 10,
    parameter int unsigned BFLY_LATENCY = 6
) (
    input logic       clk,
    input logic       reset,
    fft_seq_if.master bus
);
    localparam int unsigned SW = $clog2(FFT_N);
    localparam int unsigned JW = FFT_N - 1;

    localparam logic [JW-1:0]    LAST_J = {JW{1'b1}};
    localparam logic [SW-1:0]    LAST_S = SW'(FFT_N - 1);
    localparam logic [FFT_N-1:0] HALF   = {1'b1, {(FFT_N - 1){1'b0}}};
    localparam logic [FFT_N-1:0] NONE   = 1;
    localparam logic [JW-1:0]    JONE   = 1;
    localparam logic [SW-1:0]    SONE   = 1;

    if (BFLY_LATENCY < 1) begin : g_bad_latency
        $error("BFLY_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [JW-1:0]    j_q, j_d;
    logic [FFT_N-1:0] rcnt_q, rcnt_d;
    logic [FFT_N-1:0] rcnt_inc;

    // Stage/index of the butterfly considered for issue on this edge.
    logic             issue;
    logic [SW-1:0]    s_iss;
    logic [JW-1:0]    j_iss;

    logic             act_q, act_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [JW-1:0]    idx_q, idx_d;
    logic [FFT_N-1:0] a_q, a_d;
    logic [FFT_N-1:0] b_q, b_d;
    logic [JW-1:0]    tw_q, tw_d;

    int               pb;
    logic [FFT_N-1:0] jw;
    logic [FFT_N-1:0] span;
    logic [JW-1:0]    pos_j;
    logic [FFT_N-1:0] addr_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            j_q     <= '0;
            rcnt_q  <= '0;
            act_q   <= 1'b0;
            ctrl_q  <= 2'b00;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            rcnt_q  <= rcnt_d;
            act_q   <= act_d;
            ctrl_q  <= ctrl_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tw_q    <= tw_d;
        end
    end

    assign rcnt_inc = (bus.bfly_oact && (rcnt_q != HALF)) ? rcnt_q + NONE : rcnt_q;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        s_iss   = s_q;
        j_iss   = j_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StIssue;
                    s_iss   = '0;
                    j_iss   = '0;
                    rcnt_d  = '0;
                    issue   = !bus.hold;
                end
            end
            StIssue: begin
                rcnt_d = rcnt_inc;
                issue  = !bus.hold;
            end
            StDrain: begin
                rcnt_d = rcnt_inc;
                // Leave as soon as the final retire lands so the next stage issues right after.
                if (rcnt_inc == HALF) begin
                    if (s_q == LAST_S) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        s_iss   = s_q + SONE;
                        j_iss   = '0;
                        rcnt_d  = '0;
                        issue   = !bus.hold;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                s_iss   = '0;
                j_iss   = '0;
            end
            default: state_d = StIdle;
        endcase
        s_d = s_iss;
        j_d = j_iss;
        if (issue) begin
            if (j_iss == LAST_J) begin
                state_d = StDrain;
            end else begin
                j_d = j_iss + JONE;
            end
        end
    end

    always_comb begin
        // Operand A is j with a zero inserted at bit FFT_N-1-s; B sets that bit.
        pb     = int'(FFT_N) - 1 - int'(s_iss);
        jw     = {1'b0, j_iss};
        span   = NONE << pb;
        pos_j  = j_iss & ((JONE << pb) - JONE);
        addr_a = ((jw >> pb) << (pb + 1)) | {1'b0, pos_j};
        act_d  = issue;
        ctrl_d = 2'b00;
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        tw_d   = tw_q;
        if (issue) begin
            if (j_iss == '0) begin
                ctrl_d = 2'b01;
            end else if (j_iss == LAST_J) begin
                ctrl_d = 2'b10;
            end
            idx_d = j_iss;
            a_d   = addr_a;
            b_d   = addr_a | span;
            tw_d  = pos_j << s_iss;
        end
    end

    assign bus.busy      = (state_q == StIssue) || (state_q == StDrain);
    assign bus.done      = (state_q == StDone);
    assign bus.stage     = s_q;
    assign bus.bfly_act  = act_q;
    assign bus.bfly_ctrl = ctrl_q;
    assign bus.bfly_idx  = idx_q;
    assign bus.rd_addr_a = a_q;
    assign bus.rd_addr_b = b_q;
    assign bus.tw_addr   = tw_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at FFT_N=3 with a delay-line butterfly model.
// Cycle k is the interval after the k-th rising edge of a run; inputs set in cycle k take effect in k+1.
module tb_fft_stage_sequencer;
    localparam int unsigned FFT_N = 3;
    localparam int MAXC = 128;

    typedef struct {
        int cyc;
        int st;
        int idx;
        int a;
        int b;
        int tw;
        int ctrl;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fft_seq_if #(.FFT_N(FFT_N)) bus ();

    fft_stage_sequencer #(
        .FFT_N       (FFT_N),
        .BFLY_LATENCY(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Butterfly model: oact follows act by lat cycles.
    int          lat = 6;
    logic [15:0] pipe = '0;
    always @(posedge clk) pipe <= {pipe[14:0], bus.bfly_act};
    assign bus.bfly_oact = pipe[lat-1];

    int checks = 0;
    int errors = 0;

    bit start_v[MAXC];
    bit hold_v[MAXC];
    bit reset_v[MAXC];
    int act_l[MAXC];
    int ctrl_l[MAXC];
    int idx_l[MAXC];
    int a_l[MAXC];
    int b_l[MAXC];
    int tw_l[MAXC];
    int stage_l[MAXC];
    int busy_l[MAXC];
    int done_l[MAXC];

    vec_t tbl[12];
    int   hcyc[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            start_v[i] = 1'b0;
            hold_v[i]  = 1'b0;
            reset_v[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            act_l[k]   = bus.bfly_act;
            ctrl_l[k]  = bus.bfly_ctrl;
            idx_l[k]   = bus.bfly_idx;
            a_l[k]     = bus.rd_addr_a;
            b_l[k]     = bus.rd_addr_b;
            tw_l[k]    = bus.tw_addr;
            stage_l[k] = bus.stage;
            busy_l[k]  = bus.busy;
            done_l[k]  = bus.done;
            reset      = reset_v[k];
            bus.start  = start_v[k];
            bus.hold   = hold_v[k];
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
    endtask

    function automatic int count_act(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += act_l[i];
        return n;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += done_l[i];
        return n;
    endfunction

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 4, 0, 1};
        tbl[1]  = '{2, 0, 1, 1, 5, 1, 0};
        tbl[2]  = '{3, 0, 2, 2, 6, 2, 0};
        tbl[3]  = '{4, 0, 3, 3, 7, 3, 2};
        tbl[4]  = '{11, 1, 0, 0, 2, 0, 1};
        tbl[5]  = '{12, 1, 1, 1, 3, 2, 0};
        tbl[6]  = '{13, 1, 2, 4, 6, 0, 0};
        tbl[7]  = '{14, 1, 3, 5, 7, 2, 2};
        tbl[8]  = '{21, 2, 0, 0, 1, 0, 1};
        tbl[9]  = '{22, 2, 1, 2, 3, 0, 0};
        tbl[10] = '{23, 2, 2, 4, 5, 0, 0};
        tbl[11] = '{24, 2, 3, 6, 7, 0, 2};

        bus.start = 1'b0;
        bus.hold  = 1'b0;
        do_reset();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_act", bus.bfly_act, 0);
        check("rst_ctrl", bus.bfly_ctrl, 0);
        check("rst_stage", bus.stage, 0);
        check("rst_idx", bus.bfly_idx, 0);
        check("rst_a", bus.rd_addr_a, 0);
        check("rst_b", bus.rd_addr_b, 0);
        check("rst_tw", bus.tw_addr, 0);

        // Nominal transform, vector table.
        clear_stim();
        start_v[0] = 1'b1;
        run(34);
        for (int i = 0; i < 12; i++) begin
            int c;
            c = tbl[i].cyc;
            check($sformatf("nom_act_c%0d", c), act_l[c], 1);
            check($sformatf("nom_stage_c%0d", c), stage_l[c], tbl[i].st);
            check($sformatf("nom_idx_c%0d", c), idx_l[c], tbl[i].idx);
            check($sformatf("nom_a_c%0d", c), a_l[c], tbl[i].a);
            check($sformatf("nom_b_c%0d", c), b_l[c], tbl[i].b);
            check($sformatf("nom_tw_c%0d", c), tw_l[c], tbl[i].tw);
            check($sformatf("nom_ctrl_c%0d", c), ctrl_l[c], tbl[i].ctrl);
        end
        check("nom_issue_count", count_act(0, 33), 12);
        check("nom_done_c31", done_l[31], 1);
        check("nom_done_count", count_done(0, 33), 1);
        check("nom_busy_c0", busy_l[0], 0);
        check("nom_busy_c1", busy_l[1], 1);
        check("nom_busy_c30", busy_l[30], 1);
        check("nom_busy_c31", busy_l[31], 0);
        check("nom_busy_c32", busy_l[32], 0);

        // Hold suppresses the issues of cycles 2-3; last issue slips to cycle 6.
        do_reset();
        clear_stim();
        start_v[0] = 1'b1;
        hold_v[1]  = 1'b1;
        hold_v[2]  = 1'b1;
        run(16);
        hcyc = '{1, 4, 5, 6};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold_act_c%0d", hcyc[i]), act_l[hcyc[i]], 1);
            check($sformatf("hold_idx_c%0d", hcyc[i]), idx_l[hcyc[i]], i);
        end
        check("hold_act_c2", act_l[2], 0);
        check("hold_act_c3", act_l[3], 0);
        check("hold_ctrl_c6", ctrl_l[6], 2);
        check("hold_issue_count", count_act(0, 12), 4);
        check("hold_s1_act_c13", act_l[13], 1);
        check("hold_s1_stage_c13", stage_l[13], 1);
        check("hold_s1_ctrl_c13", ctrl_l[13], 1);

        // Start while busy and in the done cycle is ignored; start in idle restarts.
        do_reset();
        clear_stim();
        start_v[0]  = 1'b1;
        start_v[5]  = 1'b1;
        start_v[31] = 1'b1;
        start_v[32] = 1'b1;
        run(36);
        check("rs_issue_count", count_act(1, 30), 12);
        check("rs_done_c31", done_l[31], 1);
        check("rs_done_count", count_done(0, 35), 1);
        check("rs_busy_c32", busy_l[32], 0);
        check("rs_act_c32", act_l[32], 0);
        check("rs_act_c33", act_l[33], 1);
        check("rs_stage_c33", stage_l[33], 0);
        check("rs_idx_c33", idx_l[33], 0);
        check("rs_ctrl_c33", ctrl_l[33], 1);

        // Reset mid-transform (with a coincident start), then a clean transform from cycle 20.
        do_reset();
        clear_stim();
        start_v[0]  = 1'b1;
        reset_v[12] = 1'b1;
        start_v[12] = 1'b1;
        start_v[20] = 1'b1;
        run(54);
        check("mr_act_c12", act_l[12], 1);
        check("mr_act_c13", act_l[13], 0);
        check("mr_ctrl_c13", ctrl_l[13], 0);
        check("mr_idx_c13", idx_l[13], 0);
        check("mr_a_c13", a_l[13], 0);
        check("mr_b_c13", b_l[13], 0);
        check("mr_tw_c13", tw_l[13], 0);
        check("mr_stage_c13", stage_l[13], 0);
        check("mr_busy_c13", busy_l[13], 0);
        check("mr_done_c13", done_l[13], 0);
        check("mr_idle_issue_count", count_act(13, 20), 0);
        check("mr_act_c21", act_l[21], 1);
        check("mr_stage_c31", stage_l[31], 1);
        check("mr_act_c31", act_l[31], 1);
        check("mr_act_c41", act_l[41], 1);
        check("mr_stage_c41", stage_l[41], 2);
        check("mr_issue_count", count_act(21, 53), 12);
        check("mr_done_c51", done_l[51], 1);
        check("mr_done_count", count_done(0, 53), 1);

        // Longer butterfly latency stretches each stage to 13 cycles.
        do_reset();
        lat = 9;
        clear_stim();
        start_v[0] = 1'b1;
        run(43);
        check("l9_s0_count", count_act(1, 4), 4);
        check("l9_gap_count", count_act(5, 13), 0);
        check("l9_act_c14", act_l[14], 1);
        check("l9_stage_c14", stage_l[14], 1);
        check("l9_act_c27", act_l[27], 1);
        check("l9_stage_c27", stage_l[27], 2);
        check("l9_busy_c39", busy_l[39], 1);
        check("l9_done_c40", done_l[40], 1);
        check("l9_done_count", count_done(0, 42), 1);
        lat = 6;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter FFT_N, default 10: log2 of transform length (N = 2^FFT_N points, N/2 butterflies per stage).
REQ-002 SHALL have parameter BFLY_LATENCY, default 6: butterfly iact-to-oact latency (informational; drain uses retire counting, not this value).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: level-sampled request to begin a full transform.
REQ-006 SHALL have port hold, input, 1: stall; while high, no butterfly issues.
REQ-007 SHALL have port bfly_oact, input, 1: retire strobe from the butterfly's oact.
REQ-008 SHALL have port busy, output, 1: transform in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the last stage has fully retired.
REQ-010 SHALL have port stage, output, $clog2(FFT_N): current stage index s, from 0 to FFT_N-1.
REQ-011 SHALL have port bfly_act, output, 1: issue strobe to the butterfly's iact.
REQ-012 SHALL have port bfly_ctrl, output, 2: 2'b01 on the first issue of a stage, 2'b10 on the last issue, 2'b00 otherwise.
REQ-013 SHALL have port bfly_idx, output, FFT_N-1: butterfly index j, routed to input_memory_address.
REQ-014 SHALL have port rd_addr_a, output, FFT_N: read address of the A operand.
REQ-015 SHALL have port rd_addr_b, output, FFT_N: read address of the B operand.
REQ-016 SHALL have port tw_addr, output, FFT_N-1: twiddle ROM index k, selecting W_N^k.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> DRAIN -> (ISSUE for the next stage | DONE) -> IDLE.
REQ-018 In IDLE, start=1 SHALL move the FSM to ISSUE with s=0, j=0, retire count=0; busy SHALL be 1 from the next cycle.
REQ-019 In ISSUE, each cycle with hold=0 SHALL drive bfly_act=1 with the current j, then increment j; a cycle with hold=1 SHALL drive bfly_act=0 and leave j unchanged.
REQ-020 Outputs bfly_act, bfly_ctrl, bfly_idx, rd_addr_a, rd_addr_b and tw_addr SHALL be registered and mutually aligned in the same cycle; they SHALL hold no meaning while bfly_act=0.
REQ-021 Addressing for DIF stage s SHALL use span = N>>(s+1), pos = j & (span-1), and group = j>>(FFT_N-1-s).
REQ-022 rd_addr_a SHALL equal group*2*span + pos, that is, j with a 0 bit inserted at bit position FFT_N-1-s.
REQ-023 rd_addr_b SHALL equal rd_addr_a | span.
REQ-024 tw_addr SHALL equal pos<<s, truncated to FFT_N-1 bits.
REQ-025 After the issue with j=N/2-1, the FSM SHALL enter DRAIN and issue nothing further.
REQ-026 The retire counter SHALL count bfly_oact pulses in both ISSUE and DRAIN.
REQ-027 DRAIN SHALL be left on the cycle after the retire count reaches N/2; this prevents in-place read-after-write hazards between stages.
REQ-028 On leaving DRAIN with s<FFT_N-1, the FSM SHALL increment s, clear j and the retire count, and resume ISSUE, with the first issue in that next cycle.
REQ-029 On leaving DRAIN with s=FFT_N-1, the FSM SHALL enter DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 start sampled in the DONE cycle SHALL be ignored; start sampled in IDLE SHALL begin a new transform.
REQ-032 bfly_oact while IDLE or DONE SHALL be ignored.
REQ-033 The retire count SHALL saturate at N/2.
REQ-034 A hold=1 edge that coincides with the last issue SHALL delay that issue; entry to DRAIN SHALL follow the actual issue.
REQ-035 Counters SHALL wrap nowhere: j runs from 0 to N/2-1 and s runs from 0 to FFT_N-1 exactly.

Reset
REQ-036 reset=1 SHALL, at any time including mid-transform, force IDLE on the next edge, with busy=0, done=0, bfly_act=0, bfly_ctrl=0, stage=0, bfly_idx=0, rd_addr_a=0, rd_addr_b=0, tw_addr=0, and j, s and retire count all 0.
REQ-037 reset SHALL take priority over start and bfly_oact in the same cycle.

Verification (FFT_N=3, butterfly model with 6-cycle latency, hold=0 unless stated)
REQ-038 start pulse at cycle 0 -> stage 0 issues at cycles 1-4 with (a,b,tw) = (0,4,0),(1,5,1),(2,6,2),(3,7,3); bfly_ctrl = 01,00,00,10.
REQ-039 Same run -> stage 1 issues at cycles 11-14 with (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2 issues at cycles 21-24 with (0,1,0),(2,3,0),(4,5,0),(6,7,0); done=1 at cycle 31 only.
REQ-040 hold=1 at cycles 2-3 of stage 0 -> issues at cycles 1,4,5,6 with j=0,1,2,3; stage 1 first issue at cycle 13.
REQ-041 start re-asserted at cycle 5 and in the done cycle -> no effect; start at cycle 32 -> new transform, with first issue at cycle 33.
REQ-042 reset at cycle 12 -> all outputs 0 and IDLE at cycle 13; late bfly_oact pulses ignored; next start runs a clean 31-cycle transform.
REQ-043 Model latency set to 9 -> stage spacing becomes 13 cycles with no overlap; done at cycle 40.
